// File: rtl/hslp_seq_approx_mul.sv
// Sequential approximate unsigned multiplier: one exact 4x4 digit product per cycle, low-significance pairs skipped per request.
// Latency: K+1 cycles from accept to out_valid, where K = number of kept digit pairs (K=0 gives the result the next cycle).
// Backpressure: result held in DONE for as long as out_ready is low; in_ready only in IDLE, no same-cycle re-accept.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake carrying a, b (WIDTH), lvl (truncation level k), comp (bias enable)
//   out_valid/out_ready result handshake carrying prod (2*WIDTH)
//   busy                high while a request is being computed or its result is pending
module hslp_seq_approx_mul #(
    parameter int WIDTH = 8,
    parameter int LVL_W = $clog2(2*WIDTH/4)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [LVL_W-1:0]   lvl,
    input  logic               comp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic               busy
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             comp_q, comp_d;
    logic [IW-1:0]    i_q, i_d, j_q, j_d;
    logic [PW-1:0]    acc_q, acc_d, prod_q, prod_d;

    logic [3:0]       a_dig, b_dig;
    logic [7:0]       dig_prod;
    logic [IW:0]      dig_pos;
    logic [PW-1:0]    contrib;
    logic             last_pair;

    // Rounding bias 2^(4k-1); a shift past the result width wraps to zero.
    function automatic logic [PW-1:0] bias_f(input logic [LVL_W-1:0] k, input logic c);
        int sh;
        sh = 4 * int'(k) - 1;
        if (!c || (k == '0) || (sh >= PW)) begin
            return '0;
        end
        return PW'(1) << sh;
    endfunction

    // First row holding a kept pair: rows with k-i > N-1 have none.
    function automatic logic [IW-1:0] first_i(input logic [LVL_W-1:0] k);
        int t;
        t = int'(k) - (N - 1);
        return (t > 0) ? IW'(t) : '0;
    endfunction

    // First kept column within row i: j >= k-i.
    function automatic logic [IW-1:0] row_j(input logic [LVL_W-1:0] k, input int i);
        int t;
        t = int'(k) - i;
        return (t > 0) ? IW'(t) : '0;
    endfunction

    // Single 4x4 multiplier; its product is placed at digit position i+j.
    always_comb begin
        a_dig     = a_q[{i_q, 2'b00} +: 4];
        b_dig     = b_q[{j_q, 2'b00} +: 4];
        dig_prod  = a_dig * b_dig;
        dig_pos   = {1'b0, i_q} + {1'b0, j_q};
        contrib   = PW'(dig_prod) << {dig_pos, 2'b00};
        // Whenever any pair is kept, (N-1,N-1) is kept and is always the last one.
        last_pair = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            lvl_q   <= '0;
            comp_q  <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lvl_q   <= lvl_d;
            comp_q  <= comp_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        lvl_d   = lvl_q;
        comp_d  = comp_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    lvl_d  = lvl;
                    comp_d = comp;
                    acc_d  = '0;
                    if (int'(lvl) >= 2 * N - 1) begin
                        // Nothing kept: the result is just the bias, ready next cycle.
                        acc_d   = bias_f(lvl, comp);
                        prod_d  = acc_d;
                        state_d = S_DONE;
                    end else begin
                        i_d     = first_i(lvl);
                        j_d     = row_j(lvl, int'(first_i(lvl)));
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_q + contrib + (last_pair ? bias_f(lvl_q, comp_q) : '0);
                if (last_pair) begin
                    prod_d  = acc_d;
                    state_d = S_DONE;
                end else if (j_q == IW'(N - 1)) begin
                    i_d = i_q + 1'b1;
                    j_d = row_j(lvl_q, int'(i_q) + 1);
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        prod      = prod_q;
    end

endmodule
